operand_sequencer: RTL
======================

# operand_sequencer

Control and operand-storage stage directly upstream of the MMU feeder. Accepts a byte stream from the host containing four weights and four inputs and holds them in registers. Once all eight bytes are loaded, or a rerun is requested, it drives the feeder's enable, cycle counter and output-select lines through one complete 2x2 matrix-multiply pass. It then returns to accepting data.

## Interface
Parameters:
- LAST_CYCLE, default 5: final compute_cycles value of a pass; pass length is LAST_CYCLE+1 cycles. Must be ≥5 and ≤15.
- OUT_FIRST, default 2: compute_cycles value at which the first result is selected.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load_valid  in  1  host byte valid.
- load_data  in  8  host byte.
- load_ready  out  1  byte accepted on this edge if load_valid is also high; equals !busy.
- start  in  1  rerun request using stored operands.
- weight0..weight3  out  8 each  stored weights, registered.
- input0..input3  out  8 each  stored inputs, registered.
- en  out  1  feeder enable, registered.
- compute_cycles  out  4  feeder cycle index, registered.
- output_sel  out  2  result select, combinational from compute_cycles.
- busy  out  1  high in COMPUTE.
- byte_cnt  out  3  number of bytes loaded so far in the current load, 0..7.

## Operation
- Two states: LOAD (reset state) and COMPUTE.
- Handshake: a byte is accepted on a rising edge when load_valid && load_ready.

LOAD state:
- An accepted byte is written to slot byte_cnt, then byte_cnt increments.
- Slot order: 0→weight0, 1→weight1, 2→weight2, 3→weight3, 4→input0, 5→input1, 6→input2, 7→input3.
- Accepting the byte at byte_cnt==7:
  - byte_cnt wraps to 0.
  - State goes to COMPUTE.
  - en=1 and compute_cycles=0 on the same edge.
- start at byte_cnt==0 with load_valid low: goes to COMPUTE with the stored operands; en=1 and compute_cycles=0.
- start at byte_cnt!=0 (partial load): ignored. Loading continues.
- start and load_valid high together: the load wins and start is ignored for that cycle.
- load_valid may drop mid-load. byte_cnt holds and there is no timeout.

COMPUTE state:
- compute_cycles increments by 1 each cycle.
- At compute_cycles==LAST_CYCLE, the next edge sets en=0, compute_cycles=0 and state LOAD.
- load_ready=0, so load_valid is ignored and no operand register changes.
- start is ignored.

Output select:
- output_sel = (compute_cycles − OUT_FIRST)[1:0] when en && OUT_FIRST ≤ compute_cycles ≤ OUT_FIRST+3.
- output_sel = 0 otherwise.

Operand retention:
- Operand registers hold their values across passes.
- They are overwritten only by new accepted bytes.

## Timing
- Reset (rst_n low, asynchronous):
  - State LOAD.
  - byte_cnt=0, en=0, compute_cycles=0, busy=0, load_ready=1.
  - All weight and input outputs 0.
  - output_sel=0.
- Reset asserted mid-load or mid-compute aborts immediately. Stored operands are cleared.
- Load-to-compute latency: en is high in the cycle immediately after the edge that accepts the 8th byte.
- Pass length: en is high for exactly LAST_CYCLE+1 consecutive cycles, 6 by default. compute_cycles shows 0,1,…,LAST_CYCLE, one value per cycle.
- Earliest next load: load_ready returns high in the first cycle with en=0.
- Back-to-back passes: load_ready=1 and byte_cnt=0 are both true in that cycle. A start sampled there launches the next pass, and en drops for exactly one cycle between passes.
- Operand stability: weight and input outputs do not change while en=1. The feeder may sample them on any compute cycle.
- Counter width: compute_cycles never exceeds LAST_CYCLE and never wraps within a pass.

## Test plan
- Reset: hold rst_n=0 mid-pass with en=1 → en, compute_cycles, busy, byte_cnt and all operands read 0 asynchronously, before the next clock edge; load_ready=1.
- Full load: stream bytes 1..8 on consecutive cycles → weight0..3=1,2,3,4 and input0..3=5,6,7,8. en=1 and compute_cycles=0 in the cycle after byte 8 is accepted. compute_cycles runs 0..5, then en=0.
- Output select: during a default pass, sample output_sel on each cycle → 0,0,0,1,2,3 for compute_cycles 0..5; output_sel=0 once en=0.
- Gapped load and lockout:
  - Drive 8 bytes with idle gaps → result identical to the full-load case.
  - Drive load_valid=1 with byte 0xAA throughout the pass → no operand changes and load_ready=0 for all 6 cycles.
- Rerun and collision:
  - After a pass, pulse start → a new 6-cycle pass runs with operands unchanged.
  - Assert start at byte_cnt=3 → ignored.
  - Assert start together with load_valid at byte_cnt=0 → the byte is stored in weight0 and no pass starts.

Source files
------------

// File: rtl/operand_sequencer.sv
// Purpose: stores 4 weights + 4 inputs from a host byte stream and sequences one 2x2 MMU feeder pass.
// Latency: en rises the cycle after the 8th byte (or a rerun start) is taken; a pass lasts LAST_CYCLE+1 cycles.
// Backpressure: load_ready is low for the whole pass; host bytes and start are ignored while busy.
module operand_sequencer #(
    parameter int LAST_CYCLE = 5,
    parameter int OUT_FIRST  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       start,
    output logic [7:0] weight0,
    output logic [7:0] weight1,
    output logic [7:0] weight2,
    output logic [7:0] weight3,
    output logic [7:0] input0,
    output logic [7:0] input1,
    output logic [7:0] input2,
    output logic [7:0] input3,
    output logic       en,
    output logic [3:0] compute_cycles,
    output logic [1:0] output_sel,
    output logic       busy,
    output logic [2:0] byte_cnt
);

    typedef enum logic {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    localparam logic [3:0] LAST   = 4'(LAST_CYCLE);
    localparam logic [3:0] OF_LO  = 4'(OUT_FIRST);
    localparam logic [4:0] OF_HI  = 5'(OUT_FIRST + 3);

    state_t          state;
    state_t          state_nxt;
    logic [7:0][7:0] opnd;
    logic            accept;
    logic            rerun;
    logic            last;

    // A byte is taken only while idle; a rerun needs an empty load and loses to a concurrent byte.
    assign accept = load_valid && load_ready;
    assign rerun  = (state == LOAD) && start && !load_valid && (byte_cnt == 3'd0);
    assign last   = (compute_cycles == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next state: enter a pass on the 8th byte or a rerun, leave after the last compute cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if ((accept && byte_cnt == 3'd7) || rerun) state_nxt = COMPUTE;
            COMPUTE: if (last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Outputs decoded from the state flop and cycle counter; en comes straight off the state register.
    always_comb begin
        busy       = (state == COMPUTE);
        en         = busy;
        load_ready = !busy;
        output_sel = 2'b00;
        if (en && compute_cycles >= OF_LO && {1'b0, compute_cycles} <= OF_HI)
            output_sel = compute_cycles[1:0] - OF_LO[1:0];
    end

    // Byte counter and operand slots; the 3-bit counter wraps to 0 after slot 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 3'd0;
            opnd     <= '0;
        end else if (accept) begin
            opnd[byte_cnt] <= load_data;
            byte_cnt       <= byte_cnt + 3'd1;
        end
    end

    // Cycle index: counts through the pass and is parked at 0 while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            compute_cycles <= 4'd0;
        else if (state == COMPUTE && !last)    compute_cycles <= compute_cycles + 4'd1;
        else                                   compute_cycles <= 4'd0;
    end

    assign weight0 = opnd[0];
    assign weight1 = opnd[1];
    assign weight2 = opnd[2];
    assign weight3 = opnd[3];
    assign input0  = opnd[4];
    assign input1  = opnd[5];
    assign input2  = opnd[6];
    assign input3  = opnd[7];

endmodule
